// File: rtl/counter_uart_tx.sv
// Snapshots a counter value and serialises it as two 8N1 UART frames (high byte first).
// The line idles high; busy covers both frames, and done pulses as busy falls.
module counter_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              send,
    output logic              txd,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic          byte_sel;
    logic [15:0]   shadow;
    logic [15:0]   padded;
    logic [7:0]    cur_byte;
    logic [2:0]    next_idx;
    logic          baud_wrap;

    always_comb begin
        padded = '0;
        padded[DATA_W-1:0] = value;
    end

    assign cur_byte  = byte_sel ? shadow[7:0] : shadow[15:8];
    assign baud_wrap = (baud == BAUD_LAST);
    assign next_idx  = bit_idx + 3'd1;

    // txd is loaded one bit ahead at each wrap so the line stays a pure register output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
            shadow   <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                baud <= baud_wrap ? '0 : baud + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (send) begin
                        shadow   <= padded;
                        byte_sel <= 1'b0;
                        baud     <= '0;
                        state    <= START;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= cur_byte[0];
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= next_idx;
                            txd     <= cur_byte[next_idx];
                        end
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            state    <= START;
                            txd      <= 1'b0;
                        end else begin
                            byte_sel <= 1'b0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_uart_tx.sv
// Randomised scoreboard bench for counter_uart_tx: a timing model predicts busy/done
// and queues expected words; a monitor decodes the line at bit centres.
module tb_counter_uart_tx;
    localparam int C  = 4;
    localparam int DW = 14;
    localparam int FRAME_CYCLES = 20 * C;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] value = '0;
    logic          send = 1'b0;
    logic          txd, busy, done;

    counter_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .value(value), .send(send),
        .txd(txd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [15:0] exp_q[$];
    int          rem = 0;
    logic        exp_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // Expected line level for bit slot k (0..19) of a two-frame transfer.
    function automatic logic frame_bit(input logic [15:0] w, input int k);
        logic [7:0] b;
        int p;
        b = (k < 10) ? w[15:8] : w[7:0];
        p = k % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    // Reference model: a request is taken only when no transfer is outstanding;
    // a transfer lasts FRAME_CYCLES cycles and done marks the cycle after it.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                rem = 0;
                exp_done = 1'b0;
            end else begin
                exp_done = 1'b0;
                if (rem == 0) begin
                    if (send) begin
                        exp_q.push_back({2'b00, value});
                        rem = FRAME_CYCLES;
                    end
                end else begin
                    rem--;
                    if (rem == 0) exp_done = 1'b1;
                end
            end
        end
    end

    logic        in_frame = 1'b0;
    logic        have_exp = 1'b0;
    logic [15:0] cur = '0;
    int          cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                check("busy_vs_model", 32'(busy), 32'(rem > 0));
                check("done_vs_model", 32'(done), 32'(exp_done));
                if (busy) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        cyc = 0;
                        have_exp = (exp_q.size() != 0);
                        total++;
                        if (have_exp) begin
                            cur = exp_q.pop_front();
                            passed++;
                        end else begin
                            $display("FAIL unexpected_frame: got a transfer, expected none at %0t", $time);
                        end
                    end
                    if (have_exp && cyc < FRAME_CYCLES && (cyc % C) == C / 2)
                        check($sformatf("txd_bit%0d_w%04h", cyc / C, cur), 32'(txd),
                              32'(frame_bit(cur, cyc / C)));
                    cyc++;
                end else begin
                    if (in_frame) begin
                        check("busy_length", 32'(cyc), 32'(FRAME_CYCLES));
                        check("done_at_end", 32'(done), 32'd1);
                        in_frame = 1'b0;
                    end
                    check("txd_idle_high", 32'(txd), 32'd1);
                end
            end
        end
    end

    task automatic pulse_send(input logic [DW-1:0] v);
        @(negedge clk);
        value = v;
        send  = 1'b1;
        @(negedge clk);
        send  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        wait_cycles(3);
        #2 rst = 1'b0;

        pulse_send(14'h1234);
        wait_cycles(90);
        pulse_send(14'h3FFF);
        wait_cycles(90);

        // Value changes the cycle after the request; the line must carry 0x0001.
        @(negedge clk);
        value = 14'h0001;
        send  = 1'b1;
        @(negedge clk);
        send  = 1'b0;
        value = 14'h2AAA;
        wait_cycles(90);

        // Requests inside a transfer are dropped.
        pulse_send(DW'($urandom));
        wait_cycles(8);
        pulse_send(DW'($urandom));
        wait_cycles(38);
        pulse_send(DW'($urandom));
        wait_cycles(60);

        // Held request: back-to-back transfers with fresh snapshots.
        @(negedge clk);
        send = 1'b1;
        for (int i = 0; i < 200; i++) begin
            value = DW'($urandom);
            @(negedge clk);
        end
        send = 1'b0;
        wait_cycles(90);

        for (int i = 0; i < 800; i++) begin
            value = DW'($urandom);
            send  = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        send = 1'b0;
        wait_cycles(90);

        // Reset inside the data bits of the first frame.
        pulse_send(14'h2C5A);
        wait_cycles(12);
        #2 rst = 1'b1;
        #1;
        check("midreset_txd", 32'(txd), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        wait_cycles(2);
        #2 rst = 1'b0;
        wait_cycles(2);
        pulse_send(14'h05A5);
        wait_cycles(90);

        check("all_frames_seen", 32'(exp_q.size()), 32'd0);
        check("no_open_frame", 32'(in_frame), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
